// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared definitions for the one-hot pulse decoder: FSM state encoding and
// elaboration-time sizing helpers.
package onehot_pulse_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((32'sd1 << result) < value) begin
         result = result + 32'sd1;
      end
      return result;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/onehot_pulse_decoder_dec.sv
// Combinational binary-to-one-hot decode with an in-range flag; lines beyond
// OUT_W are simply absent, so an out-of-range code decodes to all-zero.
module onehot_dec #(
   parameter int CODE_W = 3,
   parameter int OUT_W  = 8
) (
   input  logic [CODE_W-1:0] code,
   output logic [OUT_W-1:0]  dec,
   output logic              in_range
);

   // decode each implemented line independently
   always_comb begin
      dec = {OUT_W{1'b0}};
      for (int i = 0; i < OUT_W; i++) begin
         dec[i] = (code == CODE_W'(i));
      end
   end

   assign in_range = |dec;

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Accepts a binary code over valid/ready and drives the matching one-hot line
// for PULSE_LEN cycles, followed by GAP_LEN forced-idle cycles.
module onehot_pulse_decoder #(
   parameter int CODE_W    = 3,
   parameter int OUT_W     = 8,
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] code,
   output logic [OUT_W-1:0]  onehot,
   output logic              busy,
   output logic              done,
   output logic              err
);
   import onehot_pulse_decoder_pkg::*;

   localparam int CNT_W = clog2(max2(PULSE_LEN, GAP_LEN)) + 1;
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic GAP_EN      = (GAP_LEN > 0);
   localparam logic SHORT_PULSE = (PULSE_LEN == 1);

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [OUT_W-1:0]   onehot_r;
   logic               busy_r;
   logic               done_r;
   logic               err_r;
   logic [OUT_W-1:0]   dec_s;
   logic               in_range_s;
   logic               rdy_s;
   logic               xfer_s;

   onehot_dec #(
      .CODE_W (CODE_W),
      .OUT_W  (OUT_W)
   ) u_dec (
      .code     (code),
      .dec      (dec_s),
      .in_range (in_range_s)
   );

   // last DRIVE cycle also accepts when there is no gap, giving back-to-back pulses
   assign rdy_s  = ~rst & ((state_r == ST_IDLE) |
                           ((state_r == ST_DRIVE) & (cnt_r == CNT_ZERO) & ~GAP_EN));
   assign xfer_s = in_valid & rdy_s;

   // pulse FSM: state, counter and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         cnt_r    <= CNT_ZERO;
         onehot_r <= {OUT_W{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (xfer_s & in_range_s) begin
                  onehot_r <= dec_s;
                  cnt_r    <= PULSE_LOAD;
                  state_r  <= ST_DRIVE;
                  busy_r   <= 1'b1;
                  done_r   <= SHORT_PULSE;
               end else begin
                  err_r <= xfer_s;
               end
            end
            ST_DRIVE: begin
               if (cnt_r != CNT_ZERO) begin
                  cnt_r  <= cnt_r - CNT_ONE;
                  done_r <= (cnt_r == CNT_ONE);
               end else if (GAP_EN) begin
                  onehot_r <= {OUT_W{1'b0}};
                  cnt_r    <= GAP_LOAD;
                  state_r  <= ST_GAP;
               end else if (xfer_s & in_range_s) begin
                  onehot_r <= dec_s;
                  cnt_r    <= PULSE_LOAD;
                  done_r   <= SHORT_PULSE;
               end else begin
                  // an out-of-range code taken here is consumed and flagged
                  onehot_r <= {OUT_W{1'b0}};
                  state_r  <= ST_IDLE;
                  busy_r   <= 1'b0;
                  err_r    <= xfer_s;
               end
            end
            ST_GAP: begin
               if (cnt_r != CNT_ZERO) begin
                  cnt_r <= cnt_r - CNT_ONE;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               cnt_r    <= CNT_ZERO;
               onehot_r <= {OUT_W{1'b0}};
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = rdy_s;
   assign onehot   = onehot_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign err      = err_r;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Bench for onehot_pulse_decoder: four parameterisations checked every cycle
// against a timestamp model of each pulse, plus directed scenario checks.
module tb_onehot_pulse_decoder;

   localparam int PL[4] = '{4, 2, 4, 1};
   localparam int GL[4] = '{1, 0, 1, 1};
   localparam int WL[4] = '{8, 8, 6, 8};

   logic       clk;
   logic       rst;
   logic       vld [4];
   logic [2:0] cd  [4];
   logic       rdy [4];
   logic       dn  [4];
   logic       er  [4];
   logic       bsy [4];
   logic [7:0] oh  [4];
   logic [5:0] oh6;

   int checks;
   int failures;
   int cyc;
   bit have [4];
   int tacc [4];
   int cacc [4];
   int pulses_dut;
   int pulses_mdl;

   onehot_pulse_decoder #(.CODE_W(3), .OUT_W(8), .PULSE_LEN(4), .GAP_LEN(1)) u_def (
      .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .code(cd[0]),
      .onehot(oh[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]));
   onehot_pulse_decoder #(.CODE_W(3), .OUT_W(8), .PULSE_LEN(2), .GAP_LEN(0)) u_g0 (
      .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .code(cd[1]),
      .onehot(oh[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]));
   onehot_pulse_decoder #(.CODE_W(3), .OUT_W(6), .PULSE_LEN(4), .GAP_LEN(1)) u_w6 (
      .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .code(cd[2]),
      .onehot(oh6), .busy(bsy[2]), .done(dn[2]), .err(er[2]));
   onehot_pulse_decoder #(.CODE_W(3), .OUT_W(8), .PULSE_LEN(1), .GAP_LEN(1)) u_p1 (
      .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(rdy[3]), .code(cd[3]),
      .onehot(oh[3]), .busy(bsy[3]), .done(dn[3]), .err(er[3]));

   assign oh[2] = {2'b00, oh6};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0h exp=%0h time=%0t", tag, got, exp, $time);
      end
   endtask

   // model: a pulse accepted in cycle t drives cycles t+1..t+P, then G idle cycles
   function automatic bit in_rng(input int i);
      return have[i] && (cacc[i] < WL[i]);
   endfunction
   function automatic bit m_ready(input int i, input int m);
      if (!have[i] || cacc[i] >= WL[i]) return 1'b1;
      if (GL[i] == 0) return m >= tacc[i] + PL[i];
      return m >= tacc[i] + PL[i] + GL[i] + 1;
   endfunction
   function automatic logic [31:0] m_onehot(input int i, input int m);
      if (in_rng(i) && m > tacc[i] && m <= tacc[i] + PL[i]) return 32'd1 << cacc[i];
      return 32'd0;
   endfunction
   function automatic bit m_busy(input int i, input int m);
      return in_rng(i) && m > tacc[i] && m <= tacc[i] + PL[i] + GL[i];
   endfunction
   function automatic bit m_done(input int i, input int m);
      return in_rng(i) && m == tacc[i] + PL[i];
   endfunction
   function automatic bit m_err(input int i, input int m);
      return have[i] && (cacc[i] >= WL[i]) && m == tacc[i] + 1;
   endfunction

   // model update: record the most recent accepted code per instance
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc <= 0;
         for (int i = 0; i < 4; i++) have[i] <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (vld[i] && m_ready(i, cyc)) begin
               have[i] <= 1'b1;
               tacc[i] <= cyc;
               cacc[i] <= int'(cd[i]);
               if (i == 3 && int'(cd[i]) < WL[i]) pulses_mdl <= pulses_mdl + 1;
            end
         end
         cyc <= cyc + 1;
      end
   end

   // compare every instance against the model away from the active edge
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         check($sformatf("onehot0_%0d", i), 32'($onehot0(oh[i])), 32'd1);
         if (rst) begin
            check($sformatf("rst_onehot_%0d", i), 32'(oh[i]), 32'd0);
            check($sformatf("rst_ready_%0d", i), 32'(rdy[i]), 32'd0);
            check($sformatf("rst_busy_%0d", i), 32'(bsy[i]), 32'd0);
         end else begin
            check($sformatf("ready_%0d", i), 32'(rdy[i]), 32'(m_ready(i, cyc)));
            check($sformatf("onehot_%0d", i), 32'(oh[i]), m_onehot(i, cyc));
            check($sformatf("busy_%0d", i), 32'(bsy[i]), 32'(m_busy(i, cyc)));
            check($sformatf("done_%0d", i), 32'(dn[i]), 32'(m_done(i, cyc)));
            check($sformatf("err_%0d", i), 32'(er[i]), 32'(m_err(i, cyc)));
         end
      end
      if (oh[3] != 8'd0) pulses_dut = pulses_dut + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      logic [7:0] vals [10];
      logic [7:0] v;
      logic [7:0] iso;
      int msb;
      int budget;

      checks = 0; failures = 0; pulses_dut = 0; pulses_mdl = 0;
      for (int i = 0; i < 4; i++) begin vld[i] = 1'b0; cd[i] = 3'd0; end
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(2);

      // default parameters, code 5
      vld[0] = 1'b1; cd[0] = 3'd5;
      tick();
      vld[0] = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         check($sformatf("def_onehot_c%0d", k), 32'(oh[0]), (k <= 4) ? 32'h20 : 32'h0);
         check($sformatf("def_done_c%0d", k), 32'(dn[0]), 32'(k == 4));
         check($sformatf("def_ready_c%0d", k), 32'(rdy[0]), 32'(k == 6));
         if (k < 6) tick();
      end
      idle(4);

      // no gap: codes 1 then 6 held valid give 02,02,40,40
      vld[1] = 1'b1; cd[1] = 3'd1;
      tick();
      cd[1] = 3'd6;
      check("g0_c1", 32'(oh[1]), 32'h02);
      tick();
      check("g0_c2", 32'(oh[1]), 32'h02);
      tick();
      vld[1] = 1'b0;
      check("g0_c3", 32'(oh[1]), 32'h40);
      tick();
      check("g0_c4", 32'(oh[1]), 32'h40);
      tick();
      check("g0_c5", 32'(oh[1]), 32'h00);
      idle(3);

      // OUT_W=6: code 7 is an error, then code 2
      vld[2] = 1'b1; cd[2] = 3'd7;
      tick();
      vld[2] = 1'b0;
      check("w6_err", 32'(er[2]), 32'd1);
      check("w6_onehot_zero", 32'(oh6), 32'd0);
      check("w6_ready", 32'(rdy[2]), 32'd1);
      tick();
      check("w6_err_clear", 32'(er[2]), 32'd0);
      vld[2] = 1'b1; cd[2] = 3'd2;
      tick();
      vld[2] = 1'b0;
      check("w6_code2", 32'(oh6), 32'h04);
      idle(6);

      // reset during the second cycle of a pulse
      vld[0] = 1'b1; cd[0] = 3'd3;
      tick();
      vld[0] = 1'b0;
      tick();
      check("mid_onehot_before", 32'(oh[0]), 32'h08);
      rst = 1'b1;
      #1;
      check("mid_rst_onehot", 32'(oh[0]), 32'd0);
      check("mid_rst_busy", 32'(bsy[0]), 32'd0);
      check("mid_rst_done", 32'(dn[0]), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      vld[0] = 1'b1; cd[0] = 3'd0;
      tick();
      vld[0] = 1'b0;
      check("post_rst_code0", 32'(oh[0]), 32'h01);
      idle(6);

      // loopback: highest set bit of each input selects the line
      vals = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h82, 8'h00};
      vals[9] = 8'($urandom_range(1, 255));
      for (int n = 0; n < 10; n++) begin
         v = vals[n];
         msb = 0;
         for (int j = 0; j < 8; j++) if (v[j]) msb = j;
         iso = v;
         while ((iso & (iso - 8'd1)) != 8'd0) iso = iso & (iso - 8'd1);
         budget = 20;
         while (!rdy[0] && budget > 0) begin tick(); budget--; end
         if (budget == 0) check("loop_ready_timeout", 32'd0, 32'd1);
         vld[0] = 1'b1; cd[0] = 3'(msb);
         tick();
         vld[0] = 1'b0;
         check($sformatf("loopback_%0h", v), 32'(oh[0]), 32'(iso));
      end
      idle(6);

      // random traffic on every instance, model checked each cycle
      for (int k = 0; k < 10000; k++) begin
         for (int i = 0; i < 4; i++) begin
            vld[i] = 1'($urandom_range(0, 1));
            cd[i]  = 3'($urandom_range(0, 7));
         end
         tick();
      end
      for (int i = 0; i < 4; i++) vld[i] = 1'b0;
      idle(8);
      check("p1_pulse_count", 32'(pulses_dut), 32'(pulses_mdl));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
